// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
//   Shared constants and helpers for the sixteen-channel PWM output driver.
//
//   PWM_CNT_W           width of the PWM period counter and duty value
//   PWM_DUTY_FULL       duty code meaning "always on" (100 %, not 255/256)
//   PWM_NUM_CH          number of output channels
//   PWM_CLK_DIV_DEFAULT default clk cycles per PWM counter step
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int unsigned PWM_CNT_W           = 8;
  localparam logic [PWM_CNT_W-1:0] PWM_DUTY_FULL = 8'hFF;
  localparam int unsigned PWM_NUM_CH          = 16;
  localparam int unsigned PWM_CLK_DIV_DEFAULT = 3333;

  // PWM level for a given counter position and duty code.
  // Full-scale duty is special-cased so that 8'hFF is a solid high rather
  // than dropping out for the last counter step of each period.
  function automatic logic pwm_level(input logic [PWM_CNT_W-1:0] cnt,
                                     input logic [PWM_CNT_W-1:0] duty);
    return (duty == PWM_DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// -----------------------------------------------------------------------------
// pwm_prescaler
//   Free-running divider producing a one-cycle tick every CLK_DIV clk cycles.
//   The counter runs 0..CLK_DIV-1 and tick is high while it holds CLK_DIV-1,
//   so CLK_DIV = 1 yields a tick on every cycle.
//
//   Parameters:
//     CLK_DIV  clk cycles per tick (>= 1)
//   Ports:
//     clk    in   system clock
//     rst_n  in   asynchronous active-low reset
//     tick   out  high for one cycle at the end of each division interval
// -----------------------------------------------------------------------------
module pwm_prescaler #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  // A 1-bit counter is still needed for CLK_DIV = 1 (it simply stays at 0).
  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  assign tick = (div_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// -----------------------------------------------------------------------------
// pwm_peripheral
//   Sixteen-channel output driver fed by the SPI register file. One shared
//   8-bit PWM waveform is generated from clk through a prescaler; each channel
//   is forced low, driven static high, or driven with the PWM level according
//   to its output-enable and PWM-select bits. All PWM channels share a single
//   counter and are therefore phase-aligned.
//
//   Build option:
//     PWM_SHADOW_EN  when defined, the duty value is captured into a shadow
//                    register at each period boundary, so duty changes only
//                    take effect on the next period (no runt pulses). When
//                    undefined, the duty input is used directly and a change
//                    applies on the next cycle.
//
//   Parameters:
//     CLK_DIV          clk cycles per PWM counter step (>= 1);
//                      period = 256 * CLK_DIV clk cycles
//   Ports:
//     clk              in   system clock
//     rst_n            in   asynchronous active-low reset
//     en_reg_out_7_0   in   output enable, channels 7..0
//     en_reg_out_15_8  in   output enable, channels 15..8
//     en_reg_pwm_7_0   in   PWM select, channels 7..0
//     en_reg_pwm_15_8  in   PWM select, channels 15..8
//     pwm_duty_cycle   in   requested duty in 1/256 period units (FF = 100 %)
//     out              out  registered channel outputs
//     pwm_sync         out  registered one-cycle pulse at each period start
// -----------------------------------------------------------------------------
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = PWM_CLK_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        pwm_sync
);

  logic                  tick;
  logic                  wrap;
  logic                  lvl;
  logic [PWM_CNT_W-1:0]  pwm_cnt;
  logic [PWM_CNT_W-1:0]  duty_act;
  logic [PWM_NUM_CH-1:0] en_out;
  logic [PWM_NUM_CH-1:0] en_pwm;
  logic [PWM_NUM_CH-1:0] out_d;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // ---------------------------------------------------------------------------
  // Prescaler: one tick per counter step
  // ---------------------------------------------------------------------------
  pwm_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // ---------------------------------------------------------------------------
  // Period counter; wraps 255 -> 0 on the last tick of the period
  // ---------------------------------------------------------------------------
  assign wrap = tick && (pwm_cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + PWM_CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Active duty source
  // ---------------------------------------------------------------------------
`ifdef PWM_SHADOW_EN
  // Loaded on the same edge the counter returns to 0, so the new value
  // governs the whole of the following period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_act <= '0;
    end else if (wrap) begin
      duty_act <= pwm_duty_cycle;
    end
  end
`else
  assign duty_act = pwm_duty_cycle;
`endif

  // ---------------------------------------------------------------------------
  // Shared PWM level and per-channel output mux
  // ---------------------------------------------------------------------------
  assign lvl = pwm_level(pwm_cnt, duty_act);

  // Disabled channels are forced low; enabled non-PWM channels are high;
  // enabled PWM channels follow the shared level.
  always_comb begin
    out_d = en_out & (~en_pwm | {PWM_NUM_CH{lvl}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out      <= '0;
      pwm_sync <= 1'b0;
    end else begin
      out      <= out_d;
      pwm_sync <= wrap;
    end
  end

endmodule

// File: tb/tb_pwm_peripheral.sv
// -----------------------------------------------------------------------------
// tb_pwm_peripheral
//   Scoreboard bench for pwm_peripheral with CLK_DIV = 4 (1024-cycle period).
//   The reference model tracks elapsed clk edges since reset release and
//   derives counter position and period boundaries arithmetically.
// -----------------------------------------------------------------------------
module tb_pwm_peripheral;

  localparam int unsigned DIV = 4;
  localparam int unsigned PER = 256 * DIV;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  en_reg_out_7_0 = 8'hFF;
  logic [7:0]  en_reg_out_15_8 = 8'hFF;
  logic [7:0]  en_reg_pwm_7_0 = 8'hFF;
  logic [7:0]  en_reg_pwm_15_8 = 8'hFF;
  logic [7:0]  pwm_duty_cycle = 8'h80;
  logic [15:0] out;
  logic        pwm_sync;

  pwm_peripheral #(
    .CLK_DIV (DIV)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .pwm_sync        (pwm_sync)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;

  // Scoreboard: {pwm_sync, out} expected after each posedge
  logic [16:0] sb_q[$];

  // Reference model state
  int unsigned k = 0;            // clk edges counted since reset release
  logic [7:0]  shadow_duty = 8'h00;

  // Per-period high-time check on out[0]; win_exp < 0 disables it.
  int          win_exp = -1;
  int unsigned win_gen = 0;

  // Current stimulus settings
  logic [15:0] cur_eo = 16'hFFFF;
  logic [15:0] cur_ep = 16'hFFFF;
  logic [7:0]  cur_d  = 8'h80;

  function automatic logic [16:0] model(input logic [15:0] eo, input logic [15:0] ep,
                                        input logic [7:0] duty_eff, input int unsigned kk);
    int unsigned pos;
    logic lv;
    logic [15:0] o;
    logic s;
    pos = (kk / DIV) % 256;
    lv  = (duty_eff == 8'hFF) ? 1'b1 : (pos < duty_eff);
    for (int i = 0; i < 16; i++) begin
      if (!eo[i])      o[i] = 1'b0;
      else if (!ep[i]) o[i] = 1'b1;
      else             o[i] = lv;
    end
    s = ((kk % PER) == PER - 1);
    return {s, o};
  endfunction

  // Apply one cycle of stimulus at the falling edge and predict the response.
  task automatic step(input logic r);
    logic was;
    logic [7:0] deff;
    @(negedge clk);
    was = rst_n;
    rst_n = r;
    {en_reg_out_15_8, en_reg_out_7_0} = cur_eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = cur_ep;
    pwm_duty_cycle = cur_d;
    #1;
    if (was && !r) begin
      checks++;
      if (out !== 16'h0000 || pwm_sync !== 1'b0) begin
        failures++;
        $display("FAIL async_reset: out=%h sync=%b, required out=0000 sync=0", out, pwm_sync);
      end
    end
    if (!r) begin
      sb_q.push_back(17'h0);
      k = 0;
      shadow_duty = 8'h00;
    end else begin
`ifdef PWM_SHADOW_EN
      deff = shadow_duty;
`else
      deff = cur_d;
`endif
      sb_q.push_back(model(cur_eo, cur_ep, deff, k));
      if ((k % PER) == PER - 1) shadow_duty = cur_d;
      k++;
    end
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b1);
  endtask

  task automatic set_window(input int e);
    win_exp = e;
    win_gen++;
  endtask

  // Monitor: compare every registered output sample against the scoreboard,
  // and total out[0] high time between consecutive pwm_sync pulses.
  initial begin : monitor
    logic [16:0] exp_v;
    int          hi;
    int unsigned seen_gen;
    bit          armed;
    hi = 0;
    seen_gen = 0;
    armed = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_v = sb_q.pop_front();
        checks++;
        if ({pwm_sync, out} !== exp_v) begin
          failures++;
          $display("FAIL sb_out t=%0t: out=%h sync=%b, required out=%h sync=%b",
                   $time, out, pwm_sync, exp_v[15:0], exp_v[16]);
        end
        if (seen_gen != win_gen) begin
          seen_gen = win_gen;
          armed = 0;
        end
        hi += int'(out[0]);
        if (pwm_sync === 1'b1) begin
          if (armed && win_exp >= 0) begin
            checks++;
            if (hi != win_exp) begin
              failures++;
              $display("FAIL high_time t=%0t: out[0] high %0d cycles, required %0d",
                       $time, hi, win_exp);
            end
          end
          armed = 1;
          hi = 0;
        end
      end
    end
  end

  initial begin : stim
    int unsigned guard;

    // Reset held with everything enabled
    cur_eo = 16'hFFFF; cur_ep = 16'hFFFF; cur_d = 8'h80;
    for (int i = 0; i < 8; i++) step(1'b0);

    // Static outputs
    cur_eo = 16'h00FF; cur_ep = 16'h0000;
    set_window(int'(PER));
    run(3 * PER);

    // Nominal duty and extremes on channel 0
    cur_eo = 16'hFFFF; cur_ep = 16'h0001;
    cur_d = 8'h80; set_window(512);  run(3 * PER + 17);
    cur_d = 8'h00; set_window(0);    run(3 * PER);
    cur_d = 8'hFF; set_window(int'(PER)); run(3 * PER);
    cur_d = 8'h01; set_window(4);    run(3 * PER);

    // Mid-period duty change at counter position 100
    set_window(-1);
    cur_d = 8'h40;
    run(2 * PER);
    guard = 0;
    while ((k % PER) != 100 * DIV && guard < 2 * PER) begin
      step(1'b1);
      guard++;
    end
    cur_d = 8'hC0;
    run(2 * PER);

    // Reset in the middle of a period (counter position 150)
    cur_ep = 16'hAAAA;
    guard = 0;
    while ((k % PER) != 150 * DIV && guard < 2 * PER) begin
      step(1'b1);
      guard++;
    end
    for (int i = 0; i < 5; i++) step(1'b0);
    run(PER + 100);

    // Randomized enables and duty
    for (int s = 0; s < 20; s++) begin
      cur_eo = 16'($urandom);
      cur_ep = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       cur_d = 8'h00;
        1:       cur_d = 8'hFF;
        default: cur_d = 8'($urandom);
      endcase
      run($urandom_range(20, 600));
    end

    // Drain the scoreboard
    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
